// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline control slice: hazard FSM encoding,
// architectural register constants and the opcode values decoded by control.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_FREEZE  = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/hazard_evt_cnt.sv
// Free-running event counter for pipeline debug statistics; wraps silently
// at 2^CNT_W and is cleared by the synchronous pipeline reset.
module hazard_evt_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: resolves
// load-use stalls, MEM-stage branch flushes and data-memory wait states.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic             wait_err
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    hz_state_t         cur_state;
    hz_state_t         next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rs_match;
    logic              rt_match;
    logic              lu;
    logic              br;
    logic              fz;
    logic              take_flush;
    logic              take_stall;

    // A load into $zero never produces a value, so it cannot create a hazard.
    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt && (ex_rt == id_rt);
        lu       = ex_memread && (ex_rt != REG_ZERO) && (rs_match || rt_match);
        br       = mem_branch_taken;
        fz       = dmem_busy;
    end

    assign take_flush = !fz && br;
    assign take_stall = !fz && !br && lu && (cur_state != ST_LDSTALL);

    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        pipe_freeze   = 1'b0;
        next_state    = ST_RUN;
        if (rst_n) begin
            if (fz) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                pipe_freeze = 1'b1;
                next_state  = ST_FREEZE;
            end else if (take_flush) begin
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                ex_mem_bubble = 1'b1;
                next_state    = ST_FLUSH;
            end else if (take_stall) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
                next_state   = ST_LDSTALL;
            end
        end
    end

    // The wait counter only measures consecutive busy cycles; wait_err latches
    // on the first busy cycle seen after the counter has already saturated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ST_RUN;
            wait_cnt  <= '0;
            wait_err  <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (fz) begin
                if (wait_cnt == WAIT_LIMIT) begin
                    wait_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign state = cur_state;

    hazard_evt_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_stall),
        .count (stall_cnt)
    );

    hazard_evt_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_flush),
        .count (flush_cnt)
    );

    hazard_evt_cnt #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fz),
        .count (freeze_cnt)
    );

endmodule
